fifo_rd_ctrl: RTL and testbench
===============================

# fifo_rd_ctrl

Read-side controller for the team's synchronous FIFOs. It pairs with a write-side wrapping pointer. It tracks occupancy from the writer's push strobes and the consumer's pop requests, and owns the wrapping read pointer into the shared storage array. It produces empty/full status and accepts pops only when data is present. It sits between the FIFO storage array and the downstream consumer, in the same clock domain as the writer.

## Interface
Parameters:
- PTR_WIDTH, 3, width of read pointer and storage address.
- DEPTH, 8, number of entries; 2 ≤ DEPTH ≤ 2^PTR_WIDTH.
- INIT_VALUE, 0, read pointer value after reset; must be < DEPTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- i__push  input  1  writer committed one entry this cycle.
- i__pop  input  1  consumer requests one entry this cycle.
- o__pop_accept  output  1  pop taken this cycle; combinational: i__pop & ~o__empty.
- o__rd_ptr  output  PTR_WIDTH  registered read address of head entry.
- o__rd_ptr__next  output  PTR_WIDTH  combinational value rd_ptr takes at next edge.
- o__occupancy  output  PTR_WIDTH+1  registered entry count, 0..DEPTH.
- o__empty  output  1  registered; occupancy == 0.
- o__full  output  1  registered; occupancy == DEPTH.
- o__overflow  output  1  sticky error: push while full without accepted pop.
- o__underflow  output  1  sticky error: pop requested while empty.

## Operation
- Accepted pop: rd_ptr advances by one. It wraps from DEPTH-1 to 0, and the compare is against DEPTH-1, not 2^PTR_WIDTH-1.
- No accepted pop: rd_ptr holds.
- Occupancy update, with accepted push = i__push & (~o__full | o__pop_accept):
  - push only: +1
  - pop only: −1
  - both or neither: unchanged
- Push while full with simultaneous accepted pop: legal; occupancy stays DEPTH.
- Push while full without pop: dropped. Occupancy stays DEPTH; o__overflow sets.
- Pop while empty: o__pop_accept=0, rd_ptr and occupancy unchanged, o__underflow sets.
- Push and pop in the same cycle while empty: no bypass. Push is taken and pop is refused. Occupancy becomes 1; o__underflow sets.
- Empty and full flags are registered, derived from the next occupancy at each edge.
- Arithmetic: occupancy is PTR_WIDTH+1 bits and never leaves 0..DEPTH. The ±1 constants are sized to avoid width-conversion warnings.

## Timing
- Reset values:
  - o__rd_ptr = INIT_VALUE
  - o__occupancy = 0
  - o__empty = 1
  - o__full = 0
  - o__overflow = 0
  - o__underflow = 0
- Reset asserted mid-operation overrides all events in that cycle. The next cycle shows reset values, and pending pushes and pops are discarded.
- Latency: a push at edge N gives o__empty=0 after edge N, so the earliest accepted pop is in cycle N+1.
- o__pop_accept and o__rd_ptr__next are same-cycle combinational. Storage read uses o__rd_ptr; the consumer samples data in the cycle o__pop_accept=1.
- Sticky flags clear only on reset.

## Configuration
- FIFO_RD_CTRL_ERR_EN:
  - Defined: o__overflow and o__underflow flops and their set logic are built as described.
  - Undefined: both ports are tied to 0 and no error flops exist.
  - Functional behaviour is identical either way; drops and refusals still occur.

## Structure
- Shared package (fifo_pkg) holds:
  - the default PTR_WIDTH and DEPTH constants
  - a typedef for the occupancy type, logic [PTR_WIDTH:0]
  - a typedef for a status struct {empty, full, overflow, underflow}
- One sub-module, wrap_ptr: a wrapping pointer with increment enable and a configurable wrap limit (DEPTH-1) and reset value. It exports current and next values. fifo_rd_ctrl instantiates it for rd_ptr.
- Occupancy and flag logic stays in fifo_rd_ctrl.

## Test plan
All scenarios use PTR_WIDTH=3, DEPTH=8, INIT_VALUE=0.
- Reset, then idle 3 cycles → rd_ptr=0, occupancy=0, empty=1, full=0, both error flags 0.
- 8 pushes, then 8 pops on consecutive cycles:
  - full=1 after the 8th push
  - each pop accepted
  - rd_ptr steps 0..7 then wraps to 0
  - empty=1 at the end
- Fill to 8, then push+pop together for 4 cycles → occupancy stays 8, full=1, rd_ptr=4, overflow=0.
- Pop while empty, then push+pop together on empty:
  - pop_accept=0 in both cycles
  - underflow=1 (if ERR_EN)
  - occupancy=1 after the push
- Fill to 8, then push alone → occupancy stays 8 and overflow=1 (if ERR_EN); with the macro undefined, overflow=0.
- DEPTH=6 variant: 6 pushes and 6 pops → rd_ptr wraps from 5 to 0. Then assert reset with occupancy=3 → the next cycle shows all reset values.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the synchronous FIFO controllers.
package fifo_pkg;

  localparam int unsigned DefPtrWidth = 3;
  localparam int unsigned DefDepth    = 8;

  // Occupancy at the default pointer width: one extra bit so DEPTH itself is representable.
  typedef logic [DefPtrWidth:0] occ_t;

  typedef struct packed {
    logic empty;
    logic full;
    logic overflow;
    logic underflow;
  } status_t;

endpackage

// File: rtl/wrap_ptr.sv
// Wrapping pointer: increments on inc_i, returns to zero after reaching LIMIT.
module wrap_ptr #(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned LIMIT       = 7,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [WIDTH-1:0] ptr_o,
  output logic [WIDTH-1:0] ptr_next_o
);

  localparam logic [WIDTH-1:0] LimitVal = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] ResetVal = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] PtrOne   = WIDTH'(1);

  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] ptr_d;

  // Next pointer: wrap against LIMIT, not the natural power-of-two rollover.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = (ptr_q == LimitVal) ? '0 : ptr_q + PtrOne;
    end
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= ResetVal;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o      = ptr_q;
  assign ptr_next_o = ptr_d;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side FIFO controller: occupancy tracking, empty/full status and wrapping read pointer.
// Build option: define FIFO_RD_CTRL_ERR_EN to build the sticky overflow/underflow flags;
// otherwise both error outputs are tied low.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_WIDTH  = DefPtrWidth,
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned INIT_VALUE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i__push,
  input  logic                 i__pop,
  output logic                 o__pop_accept,
  output logic [PTR_WIDTH-1:0] o__rd_ptr,
  output logic [PTR_WIDTH-1:0] o__rd_ptr__next,
  output logic [PTR_WIDTH:0]   o__occupancy,
  output logic                 o__empty,
  output logic                 o__full,
  output logic                 o__overflow,
  output logic                 o__underflow
);

  typedef logic [PTR_WIDTH:0] cnt_t;

  localparam cnt_t OccOne   = cnt_t'(1);
  localparam cnt_t OccDepth = cnt_t'(DEPTH);

  cnt_t    occ_q, occ_d;
  logic    empty_q, empty_d;
  logic    full_q, full_d;
  logic    pop_accept;
  logic    push_accept;
  status_t status;

  // A full FIFO still takes a push when a pop drains an entry in the same cycle.
  assign pop_accept  = i__pop & ~empty_q;
  assign push_accept = i__push & (~full_q | pop_accept);

  wrap_ptr #(
    .WIDTH       (PTR_WIDTH),
    .LIMIT       (DEPTH - 1),
    .RESET_VALUE (INIT_VALUE)
  ) u_rd_ptr (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (pop_accept),
    .ptr_o      (o__rd_ptr),
    .ptr_next_o (o__rd_ptr__next)
  );

  // Next occupancy and the flags derived from it.
  always_comb begin
    occ_d = occ_q;
    unique case ({push_accept, pop_accept})
      2'b10:   occ_d = occ_q + OccOne;
      2'b01:   occ_d = occ_q - OccOne;
      default: occ_d = occ_q;
    endcase
    empty_d = (occ_d == '0);
    full_d  = (occ_d == OccDepth);
  end

  // Occupancy and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

`ifdef FIFO_RD_CTRL_ERR_EN
  logic overflow_q, underflow_q;

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (i__push & full_q & ~pop_accept) overflow_q  <= 1'b1;
      if (i__pop & empty_q)               underflow_q <= 1'b1;
    end
  end

  assign status.overflow  = overflow_q;
  assign status.underflow = underflow_q;
`else
  assign status.overflow  = 1'b0;
  assign status.underflow = 1'b0;
`endif

  assign status.empty = empty_q;
  assign status.full  = full_q;

  assign o__pop_accept = pop_accept;
  assign o__occupancy  = occ_q;
  assign o__empty      = status.empty;
  assign o__full       = status.full;
  assign o__overflow   = status.overflow;
  assign o__underflow  = status.underflow;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: DEPTH=8 and DEPTH=6 instances, immediate-assertion checks.
module tb_fifo_rd_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, pu8, po8;
  logic       acc8, emp8, ful8, ovf8, unf8;
  logic [2:0] rd8, rdn8;
  logic [3:0] occ8;

  logic       rst6, pu6, po6;
  logic       acc6, emp6, ful6, ovf6, unf6;
  logic [2:0] rd6, rdn6;
  logic [3:0] occ6;

  int total = 0;
  int bad   = 0;

`ifdef FIFO_RD_CTRL_ERR_EN
  localparam logic ErrOn = 1'b1;
`else
  localparam logic ErrOn = 1'b0;
`endif

  fifo_rd_ctrl #(.PTR_WIDTH(3), .DEPTH(8), .INIT_VALUE(0)) u_dut8 (
    .clk             (clk),
    .reset           (rst8),
    .i__push         (pu8),
    .i__pop          (po8),
    .o__pop_accept   (acc8),
    .o__rd_ptr       (rd8),
    .o__rd_ptr__next (rdn8),
    .o__occupancy    (occ8),
    .o__empty        (emp8),
    .o__full         (ful8),
    .o__overflow     (ovf8),
    .o__underflow    (unf8)
  );

  fifo_rd_ctrl #(.PTR_WIDTH(3), .DEPTH(6), .INIT_VALUE(0)) u_dut6 (
    .clk             (clk),
    .reset           (rst6),
    .i__push         (pu6),
    .i__pop          (po6),
    .o__pop_accept   (acc6),
    .o__rd_ptr       (rd6),
    .o__rd_ptr__next (rdn6),
    .o__occupancy    (occ6),
    .o__empty        (emp6),
    .o__full         (ful6),
    .o__overflow     (ovf6),
    .o__underflow    (unf6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check8_idle(input string tag, input logic [2:0] rd, input logic [3:0] occ,
                             input logic emp, input logic ful);
    check({tag, ".rd_ptr"}, 32'(rd8), 32'(rd));
    check({tag, ".occ"}, 32'(occ8), 32'(occ));
    check({tag, ".empty"}, 32'(emp8), 32'(emp));
    check({tag, ".full"}, 32'(ful8), 32'(ful));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst8 = 1'b1; pu8 = 1'b0; po8 = 1'b0;
    rst6 = 1'b1; pu6 = 1'b0; po6 = 1'b0;
    tick();
    tick();
    rst8 = 1'b0;
    rst6 = 1'b0;

    // Reset then idle.
    repeat (3) tick();
    check8_idle("idle", 3'd0, 4'd0, 1'b1, 1'b0);
    check("idle.ovf", 32'(ovf8), 32'd0);
    check("idle.unf", 32'(unf8), 32'd0);

    // Eight pushes then eight pops.
    pu8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) check("push1.empty", 32'(emp8), 32'd0);
      tick();
    end
    pu8 = 1'b0;
    check8_idle("fill8", 3'd0, 4'd8, 1'b0, 1'b1);
    po8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("drain.acc", 32'(acc8), 32'd1);
      check("drain.rd", 32'(rd8), 32'(i));
      check("drain.rdn", 32'(rdn8), 32'((i + 1) % 8));
      tick();
    end
    po8 = 1'b0;
    check8_idle("drained", 3'd0, 4'd0, 1'b1, 1'b0);

    // Fill, then push+pop together while full.
    pu8 = 1'b1;
    repeat (8) tick();
    po8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("pp_full.acc", 32'(acc8), 32'd1);
      tick();
    end
    po8 = 1'b0;
    check8_idle("pp_full", 3'd4, 4'd8, 1'b0, 1'b1);
    check("pp_full.ovf", 32'(ovf8), 32'd0);

    // Push alone while full is dropped.
    tick();
    pu8 = 1'b0;
    check8_idle("ovf", 3'd4, 4'd8, 1'b0, 1'b1);
    check("ovf.flag", 32'(ovf8), 32'(ErrOn));

    // Drain, then pop while empty, then push+pop on empty.
    po8 = 1'b1;
    repeat (8) tick();
    po8 = 1'b0;
    check8_idle("drain2", 3'd4, 4'd0, 1'b1, 1'b0);
    check("drain2.unf", 32'(unf8), 32'd0);
    po8 = 1'b1;
    #1;
    check("unf_pop.acc", 32'(acc8), 32'd0);
    tick();
    check8_idle("unf_pop", 3'd4, 4'd0, 1'b1, 1'b0);
    check("unf_pop.flag", 32'(unf8), 32'(ErrOn));
    pu8 = 1'b1;
    #1;
    check("pp_empty.acc", 32'(acc8), 32'd0);
    tick();
    pu8 = 1'b0;
    po8 = 1'b0;
    check8_idle("pp_empty", 3'd4, 4'd1, 1'b0, 1'b0);
    check("pp_empty.unf", 32'(unf8), 32'(ErrOn));
    check("pp_empty.ovf", 32'(ovf8), 32'(ErrOn));

    // DEPTH=6: fill, drain with wrap from 5 to 0.
    pu6 = 1'b1;
    repeat (6) tick();
    pu6 = 1'b0;
    check("d6.full", 32'(ful6), 32'd1);
    check("d6.occ", 32'(occ6), 32'd6);
    po6 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("d6.acc", 32'(acc6), 32'd1);
      check("d6.rd", 32'(rd6), 32'(i));
      check("d6.rdn", 32'(rdn6), 32'((i + 1) % 6));
      tick();
    end
    po6 = 1'b0;
    check("d6.wrap", 32'(rd6), 32'd0);
    check("d6.empty", 32'(emp6), 32'd1);

    // Build occupancy 3 with rd_ptr 1, then reset mid-operation with events pending.
    pu6 = 1'b1;
    repeat (4) tick();
    pu6 = 1'b0;
    po6 = 1'b1;
    tick();
    po6 = 1'b0;
    check("d6.pre_rst.occ", 32'(occ6), 32'd3);
    check("d6.pre_rst.rd", 32'(rd6), 32'd1);
    rst6 = 1'b1;
    pu6 = 1'b1;
    po6 = 1'b1;
    tick();
    rst6 = 1'b0;
    pu6 = 1'b0;
    po6 = 1'b0;
    check("d6.rst.rd", 32'(rd6), 32'd0);
    check("d6.rst.occ", 32'(occ6), 32'd0);
    check("d6.rst.empty", 32'(emp6), 32'd1);
    check("d6.rst.full", 32'(ful6), 32'd0);
    check("d6.rst.ovf", 32'(ovf6), 32'd0);
    check("d6.rst.unf", 32'(unf6), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
